// File: rtl/sb_pattern_pkg.sv
// Shared types and helpers for the sideband pattern generator.
// Holds the FSM state encoding and the clock-pattern builder.
package sb_pattern_pkg;

    localparam int PAT_MAX = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_POST,
        ST_DONE,
        ST_TOUT
    } state_t;

    // Alternating bits, LSB = 0; callers keep the low bits they need.
    function automatic logic [PAT_MAX-1:0] clk_pattern();
        logic [PAT_MAX-1:0] p;
        p = '0;
        for (int i = 1; i < PAT_MAX; i += 2) begin
            p[i] = 1'b1;
        end
        return p;
    endfunction

    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/sb_pattern_cnt.sv
// Clear/enable saturating counter with terminal-count flag.
// Stops at LIMIT-1 so it can never wrap.
module sb_pattern_cnt
    import sb_pattern_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = cnt_width(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sb_pattern_gen_param.sv
// Sideband pattern generator: sends a beat until the partner detects it,
// then a fixed number of accepted beats, with timeout and abort.
module sb_pattern_gen_param
    import sb_pattern_pkg::*;
#(
    parameter int PATTERN_W      = 64,
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int POST_ITER      = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start_pattern_req,
    input  logic                 i_stop,
    input  logic                 i_mode,
    input  logic [PATTERN_W-1:0] i_custom_pattern,
    input  logic                 i_rx_sb_pattern_samp_done,
    input  logic                 i_ser_done,
    output logic [PATTERN_W-1:0] o_pattern,
    output logic                 o_pattern_valid,
    output logic                 o_start_pattern_done,
    output logic                 o_pattern_time_out,
    output logic                 o_busy
);

    localparam logic [PAT_MAX-1:0]   CLK_FULL = clk_pattern();
    localparam logic [PATTERN_W-1:0] CLK_PAT  = CLK_FULL[PATTERN_W-1:0];

    state_t               state;
    state_t               nxt;
    logic [PATTERN_W-1:0] beat;
    logic [PATTERN_W-1:0] new_beat;
    logic [PATTERN_W-1:0] out_beat;
    logic                 accept;
    logic                 to_tc;
    logic                 beat_tc;
    logic                 send_on;
    logic                 post_on;
    logic                 load;

    assign send_on  = (state == ST_SEND);
    assign post_on  = (state == ST_POST);
    assign accept   = o_pattern_valid && i_ser_done;
    assign new_beat = i_mode ? i_custom_pattern : CLK_PAT;
    assign load     = (state == ST_IDLE) && i_start_pattern_req && !i_stop;
    // On the start cycle the latch is not yet loaded, so forward the new beat.
    assign out_beat = load ? new_beat : beat;

    sb_pattern_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_to_cnt (
        .clk(i_clk),
        .rst(i_rst),
        .clr(!send_on),
        .en (send_on),
        .tc (to_tc)
    );

    sb_pattern_cnt #(
        .LIMIT(POST_ITER)
    ) u_beat_cnt (
        .clk(i_clk),
        .rst(i_rst),
        .clr(!post_on),
        .en (post_on && accept),
        .tc (beat_tc)
    );

    always_comb begin
        nxt = state;
        if (i_stop) begin
            nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (i_start_pattern_req) nxt = ST_SEND;
                ST_SEND: begin
                    if (i_rx_sb_pattern_samp_done) nxt = ST_POST;
                    else if (to_tc)                nxt = ST_TOUT;
                end
                ST_POST: if (accept && beat_tc) nxt = ST_DONE;
                ST_DONE: nxt = ST_IDLE;
                ST_TOUT: nxt = ST_IDLE;
                default: nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                <= ST_IDLE;
            beat                 <= '0;
            o_pattern            <= '0;
            o_pattern_valid      <= 1'b0;
            o_start_pattern_done <= 1'b0;
            o_pattern_time_out   <= 1'b0;
            o_busy               <= 1'b0;
        end else begin
            state <= nxt;
            if (load) begin
                beat <= new_beat;
            end
            if (nxt == ST_SEND || nxt == ST_POST) begin
                o_pattern       <= out_beat;
                o_pattern_valid <= 1'b1;
            end else begin
                o_pattern       <= '0;
                o_pattern_valid <= 1'b0;
            end
            o_start_pattern_done <= (nxt == ST_DONE);
            o_pattern_time_out   <= (nxt == ST_TOUT);
            o_busy               <= (nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_sb_pattern_gen_param.sv
// Bench for sb_pattern_gen_param: cycle model plus directed scenarios.
// The model tracks phase, cycles spent sending and accepted post beats.
module tb_sb_pattern_gen_param;

    localparam int W  = 64;
    localparam int TO = 100;
    localparam int PI = 4;
    localparam logic [63:0] CLKPAT = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] CUST   = 64'h0123_4567_89AB_CDEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic          samp = 1'b0;
    logic          ser = 1'b0;
    logic [W-1:0]  custom = '0;
    logic [W-1:0]  pattern;
    logic          valid;
    logic          done;
    logic          tout;
    logic          busy;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int tout_cnt = 0;

    int          m_phase = 0;
    int          m_t = 0;
    int          m_n = 0;
    logic [63:0] m_beat = '0;
    bit          chk_en = 1'b0;

    sb_pattern_gen_param #(
        .PATTERN_W(W),
        .TIMEOUT_CYCLES(TO),
        .POST_ITER(PI)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start_pattern_req(start),
        .i_stop(stop),
        .i_mode(mode),
        .i_custom_pattern(custom),
        .i_rx_sb_pattern_samp_done(samp),
        .i_ser_done(ser),
        .o_pattern(pattern),
        .o_pattern_valid(valid),
        .o_start_pattern_done(done),
        .o_pattern_time_out(tout),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int k);
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
    endtask

    // Phases: 0 idle, 1 sending, 2 post beats, 3 done pulse, 4 timeout pulse.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_phase = 0;
            m_t     = 0;
            m_n     = 0;
            m_beat  = '0;
        end else if (stop) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_t     = 0;
                    m_beat  = mode ? custom : CLKPAT;
                end
                1: begin
                    if (samp) begin
                        m_phase = 2;
                        m_n     = 0;
                    end else if (m_t == TO - 1) begin
                        m_phase = 4;
                    end else begin
                        m_t++;
                    end
                end
                2: if (ser) begin
                    m_n++;
                    if (m_n == PI) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
        chk_en = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic ev;
            ev = (m_phase == 1 || m_phase == 2);
            check("valid", {63'd0, valid}, {63'd0, ev});
            check("pattern", pattern, ev ? m_beat : 64'd0);
            check("done", {63'd0, done}, {63'd0, m_phase == 3});
            check("timeout", {63'd0, tout}, {63'd0, m_phase == 4});
            check("busy", {63'd0, busy}, {63'd0, m_phase != 0});
            if (done) done_cnt++;
            if (tout) tout_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int acc;
        int d0;
        int t0;

        repeat (3) tick();
        check("rst_pattern", pattern, 64'd0);
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_pulses", {62'd0, done, tout}, 64'd0);
        rst = 1'b0;
        tick();

        // samp_done while idle must not start anything
        samp = 1'b1;
        tick();
        samp = 1'b0;
        check("idle_samp_ignored", {63'd0, busy}, 64'd0);

        // clock pattern, partner detects at cycle 10
        ser = 1'b1;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clk_pat", pattern, CLKPAT);
        check("clk_valid", {63'd0, valid}, 64'd1);
        start = 1'b1;
        repeat (10) tick();
        start = 1'b0;
        samp = 1'b1;
        tick();
        samp = 1'b0;
        wait_done(20, k);
        check("post_len", k, 4);
        check("done_seen", {63'd0, done}, 64'd1);
        tick();
        check("done_1cyc", {63'd0, done}, 64'd0);
        check("valid_after", {63'd0, valid}, 64'd0);

        // no partner: timeout
        d0 = done_cnt;
        t0 = tout_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!tout && k < 150) begin
            tick();
            k++;
        end
        check("tout_len", k, 100);
        tick();
        check("tout_busy", {63'd0, busy}, 64'd0);
        check("tout_cnt", tout_cnt - t0, 1);
        check("tout_nodone", done_cnt - d0, 0);

        // custom pattern, input changes after start, random serializer
        mode = 1'b1;
        custom = CUST;
        start = 1'b1;
        tick();
        start = 1'b0;
        custom = 64'hFFFF_0000_FFFF_0000;
        mode = 1'b0;
        repeat (5) tick();
        check("cust_latched", pattern, CUST);
        samp = 1'b1;
        tick();
        samp = 1'b0;
        check("cust_post", pattern, CUST);
        acc = 0;
        k = 0;
        while (!done && k < 200) begin
            ser = 1'($urandom_range(0, 1));
            if (ser) acc++;
            tick();
            k++;
        end
        check("cust_accepts", acc, 4);
        check("cust_done", {63'd0, done}, 64'd1);
        ser = 1'b1;
        tick();

        // detection on the last allowed cycle wins over timeout
        t0 = tout_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        samp = 1'b1;
        tick();
        samp = 1'b0;
        check("late_post", {63'd0, valid}, 64'd1);
        check("late_notout", tout_cnt - t0, 0);
        wait_done(20, k);
        check("late_len", k, 4);
        tick();

        // abort in POST, then reset in SEND, then a clean run
        d0 = done_cnt;
        t0 = tout_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        samp = 1'b1;
        tick();
        samp = 1'b0;
        ser = 1'b0;
        repeat (2) tick();
        ser = 1'b1;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", {63'd0, busy}, 64'd0);
        check("stop_pattern", pattern, 64'd0);
        check("stop_valid", {63'd0, valid}, 64'd0);
        repeat (6) tick();
        check("stop_nopulse", (done_cnt - d0) + (tout_cnt - t0), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        start = 1'b1;
        stop = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_pattern", pattern, 64'd0);
        tick();
        check("rst_mid_nopulse", (done_cnt - d0) + (tout_cnt - t0), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_pat", pattern, CLKPAT);
        repeat (3) tick();
        samp = 1'b1;
        tick();
        samp = 1'b0;
        wait_done(20, k);
        check("rerun_len", k, 4);
        tick();
        check("rerun_done_cnt", done_cnt - d0, 1);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sb_pattern_gen_param.md
SB_PATTERN_GEN_PARAM -- requirements
Module: sb_pattern_gen_param

Interface
REQ-001 Parameter PATTERN_W, 64, width of one pattern beat in UI; even, >= 8.
REQ-002 Parameter TIMEOUT_CYCLES, 800000, cycles allowed in SEND before timeout; >= 2.
REQ-003 Parameter POST_ITER, 4, accepted beats to send after partner detection; >= 1.
REQ-004 Port i_clk  input  1  sole clock, all logic rising-edge.
REQ-005 Port i_rst  input  1  reset, synchronous, active-high.
REQ-006 Port i_start_pattern_req  input  1  single-cycle start request.
REQ-007 Port i_stop  input  1  abort; forces return to IDLE.
REQ-008 Port i_mode  input  1  0 = clock pattern, 1 = custom pattern.
REQ-009 Port i_custom_pattern  input  PATTERN_W  beat used when mode = 1.
REQ-010 Port i_rx_sb_pattern_samp_done  input  1  partner/receiver detected pattern.
REQ-011 Port i_ser_done  input  1  serializer ready; beat accepted when valid and ready both 1.
REQ-012 Port o_pattern  output  PATTERN_W  current beat.
REQ-013 Port o_pattern_valid  output  1  beat on o_pattern is valid.
REQ-014 Port o_start_pattern_done  output  1  one-cycle success pulse.
REQ-015 Port o_pattern_time_out  output  1  one-cycle timeout pulse.
REQ-016 Port o_busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, SEND, POST, DONE, TOUT.
REQ-018 IDLE: i_start_pattern_req=1 SHALL latch i_mode and i_custom_pattern and enter SEND next cycle; start in any other state SHALL be ignored.
REQ-019 Clock pattern SHALL be alternating bits, LSB = 0 (64-bit: 0xAAAA_AAAA_AAAA_AAAA).
REQ-020 o_pattern SHALL hold the latched beat and o_pattern_valid SHALL be 1 exactly in SEND and POST; otherwise o_pattern = 0, valid = 0.
REQ-021 SEND: timeout counter SHALL clear on entry and increment every cycle; i_rx_sb_pattern_samp_done=1 SHALL enter POST with beat counter cleared.
REQ-022 SEND: counter reaching TIMEOUT_CYCLES-1 without samp_done SHALL enter TOUT; samp_done in that same cycle SHALL win (POST).
REQ-023 POST: each accepted beat (valid and i_ser_done) SHALL increment beat counter; the POST_ITER-th accepted beat SHALL enter DONE next cycle.
REQ-024 DONE SHALL assert o_start_pattern_done for exactly one cycle then return to IDLE.
REQ-025 TOUT SHALL assert o_pattern_time_out for exactly one cycle then return to IDLE.
REQ-026 i_stop=1 in any state SHALL enter IDLE next cycle with no done/timeout pulse; i_stop SHALL take priority over all other inputs.
REQ-027 samp_done outside SEND SHALL be ignored; i_ser_done low SHALL stall the beat count only, never the timeout count.
REQ-028 Counter widths SHALL be $clog2 of their limits (minimum 1 bit); counters SHALL never wrap.

Reset
REQ-029 i_rst=1 at a clock edge SHALL force IDLE, clear both counters and latched pattern, drive all outputs 0, regardless of current state.
REQ-030 i_rst SHALL override i_start_pattern_req and i_stop in the same cycle.

Structure
REQ-031 Shared package sb_pattern_pkg SHALL hold the state enum and the clock-pattern generation function.
REQ-032 One sub-module sb_pattern_cnt (parametric clear/enable saturating counter with terminal-count flag) SHALL be used for both counters.

Verification (bench: PATTERN_W=64, TIMEOUT_CYCLES=100, POST_ITER=4)
REQ-033 Mode 0, start, ser_done=1, samp_done pulse at cycle 10 -> valid high with 0xAAAA_AAAA_AAAA_AAAA, done pulse 1 cycle after 4th post beat, valid low afterwards.
REQ-034 Start, no samp_done -> time_out pulse exactly 100 cycles after SEND entry, no done, busy low next cycle.
REQ-035 Mode 1, custom 0x0123_4567_89AB_CDEF changed after start, ser_done random -> o_pattern stays latched value; done only after 4 accepted beats.
REQ-036 samp_done on cycle 99 of SEND -> POST entered, no time_out pulse.
REQ-037 i_stop mid-POST, then i_rst mid-SEND on a second run -> IDLE, all outputs 0, no pulses; new start then completes normally.
